// File: rtl/tm1638_cmd_sequencer.sv
// Frame sequencer for the TM1638: walks a snapshot of the display register image and emits
// data-mode, address+data, display-control and key-read command words for the serial driver.
module tm1638_cmd_sequencer #(
    parameter int NUM_REGS       = 16,
    parameter bit SKIP_UNCHANGED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  show,
    input  logic [2:0]            brightness,
    input  logic                  read_keys,
    input  logic [8*NUM_REGS-1:0] regs,
    output logic [17:0]           cmd,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  busy,
    output logic                  done
);

    localparam logic [17:0] DATA_WRITE_CMD = 18'h00044;
    localparam logic [17:0] KEY_READ_CMD   = 18'h20046;
    localparam logic [3:0]  LAST_IDX       = 4'(NUM_REGS - 1);

    typedef enum logic [2:0] {IDLE, DATA_CMD, REGS, CTRL, READ, DONE} state_t;

    state_t      state;
    logic [3:0]  idx;
    logic        first;
    logic [7:0]  snap_regs [NUM_REGS];
    logic [7:0]  last_sent [NUM_REGS];
    logic        snap_show;
    logic [2:0]  snap_brightness;
    logic        snap_read_keys;
    logic [3:0]  last_ctrl;

    logic        accept_start;
    logic        advance;
    logic [3:0]  load_idx;
    logic [7:0]  load_data;
    logic        load_skip;
    logic        ctrl_skip;
    logic [17:0] load_word;
    logic [17:0] ctrl_word;

    // Outputs are registered, so the item to present next is prepared from the
    // index following the one currently on the bus.
    always_comb begin
        accept_start = start && (state == IDLE || state == DONE);
        advance      = !cmd_valid || cmd_ready;
        load_idx     = (state == REGS && idx != LAST_IDX) ? idx + 4'd1 : 4'd0;
        load_data    = snap_regs[load_idx];
        load_word    = {1'b0, 1'b1, load_data, 2'b11, 2'b00, load_idx};
        load_skip    = SKIP_UNCHANGED && !first && (load_data == last_sent[load_idx]);
        ctrl_word    = {10'h000, 2'b10, 2'b00, snap_show, snap_brightness};
        ctrl_skip    = SKIP_UNCHANGED && !first && ({snap_show, snap_brightness} == last_ctrl);
    end

    // NOTE: the snapshot array carries no reset; it is always loaded at frame start
    // before anything reads it, so a reset would only cost flops and routing.
    always_ff @(posedge clk) begin
        if (accept_start) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                snap_regs[i] <= regs[8*i +: 8];
            end
            snap_show       <= show;
            snap_brightness <= brightness;
            snap_read_keys  <= read_keys;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every branch sees the
    // pre-edge values of cmd, cmd_valid and idx regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 4'd0;
            first     <= 1'b1;
            cmd       <= '0;
            cmd_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            last_ctrl <= 4'd0;
            for (int i = 0; i < NUM_REGS; i++) begin
                last_sent[i] <= 8'd0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (state == DONE) begin
                        first <= 1'b0;
                    end
                    if (accept_start) begin
                        state     <= DATA_CMD;
                        idx       <= 4'd0;
                        cmd       <= DATA_WRITE_CMD;
                        cmd_valid <= 1'b1;
                        busy      <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                DATA_CMD: begin
                    if (cmd_ready) begin
                        state     <= REGS;
                        idx       <= load_idx;
                        cmd       <= load_skip ? '0 : load_word;
                        cmd_valid <= !load_skip;
                    end
                end
                REGS: begin
                    if (advance) begin
                        if (cmd_valid) begin
                            last_sent[idx] <= cmd[15:8];
                        end
                        if (idx == LAST_IDX) begin
                            state     <= CTRL;
                            cmd       <= ctrl_skip ? '0 : ctrl_word;
                            cmd_valid <= !ctrl_skip;
                        end else begin
                            idx       <= load_idx;
                            cmd       <= load_skip ? '0 : load_word;
                            cmd_valid <= !load_skip;
                        end
                    end
                end
                CTRL: begin
                    if (advance) begin
                        if (cmd_valid) begin
                            last_ctrl <= cmd[3:0];
                        end
                        state     <= READ;
                        cmd       <= snap_read_keys ? KEY_READ_CMD : '0;
                        cmd_valid <= snap_read_keys;
                    end
                end
                READ: begin
                    if (advance) begin
                        state     <= DONE;
                        cmd       <= '0;
                        cmd_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tm1638_cmd_sequencer.sv
// Bench for tm1638_cmd_sequencer: a skipping and a non-skipping instance share stimulus and are
// compared against a frame-level model of the expected command list and done timing.
module tb_tm1638_cmd_sequencer;

    localparam int N          = 16;
    localparam int DONE_CYCLE = 1 + N + 1 + 1 + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           show;
    logic [2:0]     brightness;
    logic           read_keys;
    logic [8*N-1:0] regs;
    logic           cmd_ready;
    logic [17:0]    cmd_s, cmd_n;
    logic           valid_s, valid_n, busy_s, busy_n, done_s, done_n;

    int errors = 0;
    int checks = 0;

    logic [17:0] exp_s[$], exp_n[$], got_s[$], got_n[$];

    // Reference state per instance: 0 = skipping, 1 = non-skipping
    bit          m_first [2];
    logic [7:0]  m_last  [2][N];
    logic [3:0]  m_ctrl  [2];

    logic [17:0] prev_cmd   [2];
    bit          prev_stall [2];
    bit          prev_done  [2];

    tm1638_cmd_sequencer #(.NUM_REGS(N), .SKIP_UNCHANGED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .start(start), .show(show), .brightness(brightness),
        .read_keys(read_keys), .regs(regs), .cmd(cmd_s), .cmd_valid(valid_s),
        .cmd_ready(cmd_ready), .busy(busy_s), .done(done_s)
    );

    tm1638_cmd_sequencer #(.NUM_REGS(N), .SKIP_UNCHANGED(1'b0)) dut_n (
        .clk(clk), .rst(rst), .start(start), .show(show), .brightness(brightness),
        .read_keys(read_keys), .regs(regs), .cmd(cmd_n), .cmd_valid(valid_n),
        .cmd_ready(cmd_ready), .busy(busy_n), .done(done_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int k, input logic [17:0] w);
        if (k == 0) exp_s.push_back(w);
        else        exp_n.push_back(w);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_first[k] = 1'b1;
            m_ctrl[k]  = 4'd0;
            for (int i = 0; i < N; i++) m_last[k][i] = 8'd0;
        end
    endtask

    // Appends one frame's expected commands from the current inputs
    task automatic model_frame(input int k);
        bit         skip_on;
        logic [7:0] d;
        logic [3:0] ctrl_val;
        skip_on  = (k == 0);
        ctrl_val = {show, brightness};
        push_exp(k, 18'h00044);
        for (int i = 0; i < N; i++) begin
            d = regs[8*i +: 8];
            if (!skip_on || m_first[k] || d != m_last[k][i]) begin
                push_exp(k, 18'h100C0 + 18'(d) * 18'd256 + 18'(i));
                m_last[k][i] = d;
            end
        end
        if (!skip_on || m_first[k] || ctrl_val != m_ctrl[k]) begin
            push_exp(k, 18'h00080 + 18'(ctrl_val));
            m_ctrl[k] = ctrl_val;
        end
        if (read_keys) push_exp(k, 18'h20046);
        m_first[k] = 1'b0;
    endtask

    task automatic monitor(input int k, input logic v, input logic [17:0] c, input logic d);
        if (rst) begin
            prev_stall[k] = 1'b0;
            prev_done[k]  = 1'b0;
        end else begin
            if (prev_stall[k]) begin
                check($sformatf("stall_valid_%0d", k), 32'(v), 32'd1);
                check($sformatf("stall_cmd_%0d", k), 32'(c), 32'(prev_cmd[k]));
            end
            if (prev_done[k]) check($sformatf("done_width_%0d", k), 32'(d), 32'd0);
            if (v && cmd_ready) begin
                if (k == 0) got_s.push_back(c);
                else        got_n.push_back(c);
            end
            prev_stall[k] = v && !cmd_ready;
            prev_cmd[k]   = c;
            prev_done[k]  = d;
        end
    endtask

    always @(negedge clk) begin
        monitor(0, valid_s, cmd_s, done_s);
        monitor(1, valid_n, cmd_n, done_n);
    end

    task automatic compare_frame(input string tag);
        check({tag, "_count_s"}, 32'(got_s.size()), 32'(exp_s.size()));
        for (int i = 0; i < exp_s.size() && i < got_s.size(); i++)
            check($sformatf("%s_s[%0d]", tag, i), 32'(got_s[i]), 32'(exp_s[i]));
        check({tag, "_count_n"}, 32'(got_n.size()), 32'(exp_n.size()));
        for (int i = 0; i < exp_n.size() && i < got_n.size(); i++)
            check($sformatf("%s_n[%0d]", tag, i), 32'(got_n[i]), 32'(exp_n[i]));
    endtask

    task automatic clear_queues();
        exp_s.delete(); exp_n.delete(); got_s.delete(); got_n.delete();
    endtask

    // Starts one frame, runs it to done on both instances, checks order and timing
    task automatic run_frame(input string tag, input bit rand_ready, input bit scramble,
                             input int exp_done);
        int cyc;
        int done_cyc;
        bit ds, dn;
        clear_queues();
        model_frame(0);
        model_frame(1);
        cmd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; done_cyc = -1; ds = 0; dn = 0;
        check({tag, "_first_busy"}, 32'(busy_s), 32'd1);
        check({tag, "_first_cmd"}, 32'({valid_s, cmd_s}), 32'({1'b1, 18'h00044}));
        forever begin
            if (done_s && !ds) begin
                ds = 1; done_cyc = cyc;
                check({tag, "_done_busy"}, 32'(busy_s), 32'd0);
            end
            if (done_n) dn = 1;
            if ((ds && dn) || cyc >= 2000) break;
            if (scramble && cyc == 3) begin
                regs = {$urandom, $urandom, $urandom, $urandom};
                show = 1'($urandom); brightness = 3'($urandom); read_keys = 1'($urandom);
            end
            if (rand_ready) cmd_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cyc++;
        end
        cmd_ready = 1'b1;
        check({tag, "_frame_ended"}, 32'(ds && dn), 32'd1);
        if (exp_done > 0) check({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
        compare_frame(tag);
    endtask

    initial begin
        int cyc, ndone, d1, d2;
        rst = 1'b1; start = 1'b0; show = 1'b0; brightness = 3'd0; read_keys = 1'b0;
        regs = '0; cmd_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd", 32'(cmd_s), 32'd0);
        check("rst_valid", 32'({valid_s, valid_n}), 32'd0);
        check("rst_busy", 32'({busy_s, busy_n}), 32'd0);
        check("rst_done", 32'({done_s, done_n}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_valid", 32'(valid_s), 32'd0);

        // Frame A: everything sent after reset
        regs[8*3 +: 8] = 8'hA5; show = 1'b1; brightness = 3'd7; read_keys = 1'b1;
        run_frame("A", 1'b0, 1'b0, DONE_CYCLE);
        check("A_pos4", (got_s.size() > 4) ? 32'(got_s[4]) : 32'hDEAD, 32'h1A5C3);
        check("A_ctrl", (got_s.size() > 17) ? 32'(got_s[17]) : 32'hDEAD, 32'h0008F);

        // Frame B: one register changed, no key read, starts in A's DONE cycle
        regs[8*5 +: 8] = 8'h3C; read_keys = 1'b0;
        run_frame("B", 1'b0, 1'b0, DONE_CYCLE);
        check("B_only", (got_s.size() > 1) ? 32'(got_s[1]) : 32'hDEAD, 32'h13CC5);
        check("B_noskip_count", 32'(got_n.size()), 32'(1 + N + 1));

        // start held high: back-to-back frames, starts during busy ignored
        clear_queues();
        model_frame(0); model_frame(1); model_frame(0); model_frame(1);
        start = 1'b1;
        @(posedge clk); #1;
        cyc = 1; ndone = 0; d1 = -1; d2 = -1;
        while (cyc <= 2 * DONE_CYCLE + 4) begin
            if (done_s) begin
                ndone++;
                if (ndone == 1) d1 = cyc;
                else if (ndone == 2) d2 = cyc;
            end
            if (cyc == DONE_CYCLE + 1)
                check("b2b_restart", 32'({busy_s, valid_s, cmd_s}), 32'({2'b11, 18'h00044}));
            if (cyc == 2 * DONE_CYCLE) start = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b_done_count", 32'(ndone), 32'd2);
        check("b2b_done1", 32'(d1), 32'(DONE_CYCLE));
        check("b2b_done2", 32'(d2), 32'(2 * DONE_CYCLE));
        check("b2b_idle", 32'(busy_s), 32'd0);
        compare_frame("b2b");

        // Random back-pressure with partial register updates and mid-frame input changes
        for (int f = 0; f < 6; f++) begin
            for (int j = 0; j < int'($urandom_range(0, 3)); j++)
                regs[8*$urandom_range(0, N-1) +: 8] = 8'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                show = 1'($urandom); brightness = 3'($urandom);
            end
            read_keys = 1'($urandom);
            run_frame($sformatf("rnd%0d", f), 1'b1, 1'b1, -1);
        end

        // Reset while REGS presents index 7: outputs clear, next frame resends all
        @(posedge clk); #1;
        regs[8*7 +: 8] = 8'h5A; read_keys = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 9; c++) begin
            @(posedge clk); #1;
        end
        check("mid_idx7_cmd_n", 32'(cmd_n), 32'(18'h100C7 + 18'h05A00));
        rst = 1'b1;
        #1;
        check("mid_rst_cmd", 32'({cmd_s, cmd_n}), 32'd0);
        check("mid_rst_flags", 32'({valid_s, busy_s, done_s, valid_n, busy_n, done_n}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        run_frame("after_rst", 1'b0, 1'b0, DONE_CYCLE);
        check("after_rst_all", 32'(got_s.size()), 32'(1 + N + 1 + 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
